// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter.
// Bytes are queued in a small FIFO and shifted out LSB first.
module uart_tx #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  logic [7:0] in,
    output logic       ready,
    output logic       txd,
    output logic       busy
);

    localparam int BW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [7:0]    fifo_q [DEPTH];

    logic push;
    logic pop;
    logic bit_end;
    logic has_data;

    assign ready    = (count_q != FULL);
    assign push     = valid && ready;
    assign bit_end  = (baud_q == '0);
    assign has_data = (count_q != '0);
    assign txd      = txd_q;
    assign busy     = (state_q != IDLE) || has_data;

    // Frame sequencer: next state, baud/bit counters, shifter, line level
    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? baud_q : baud_q - BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = BAUD_MAX;
                    shift_d = fifo_q[rptr_q];
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = BAUD_MAX;
                    bit_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = BAUD_MAX;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (has_data) begin
                        pop     = 1'b1;
                        state_d = START;
                        baud_d  = BAUD_MAX;
                        shift_d = fifo_q[rptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // line level follows the state being entered so txd stays registered
        txd_d = 1'b1;
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping: occupancy and pointers
    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    end

    // FIFO storage; pointers are cleared on reset so contents need no reset
    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo_q[wptr_q] <= in;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed stimulus against a frame-schedule model.
// Two instances: a fast divider (4) and the default divider (868).
module tb_uart_tx;

    localparam int C  = 4;
    localparam int CB = 868;
    localparam int D  = 4;

    logic       clk;
    logic       reset;
    logic       valid;
    logic [7:0] din;
    logic       ready;
    logic       txd;
    logic       busy;
    logic       valid_b;
    logic [7:0] din_b;
    logic       ready_b;
    logic       txd_b;
    logic       busy_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: bytes waiting, and the one frame currently on the line
    int pend [2][$];
    int ls   [2];
    int lb   [2];
    int lend [2];
    bit have [2];

    uart_tx #(.CLK_PER_BIT(C), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .in    (din),
        .ready (ready),
        .txd   (txd),
        .busy  (busy)
    );

    uart_tx #(.CLK_PER_BIT(CB), .DEPTH(D)) dut_b (
        .clk   (clk),
        .reset (reset),
        .valid (valid_b),
        .in    (din_b),
        .ready (ready_b),
        .txd   (txd_b),
        .busy  (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int cpb(input int i);
        return (i == 0) ? C : CB;
    endfunction

    // Line level expected after edge cyc: start 0, data LSB first, stop 1
    function automatic logic exp_txd(input int i);
        int off;
        int b;
        if (!have[i] || cyc >= lend[i]) return 1'b1;
        off = (cyc - ls[i]) / cpb(i);
        b = lb[i];
        if (off == 0) return 1'b0;
        if (off == 9) return 1'b1;
        return b[off-1];
    endfunction

    function automatic logic exp_busy(input int i);
        return (pend[i].size() > 0) || (have[i] && cyc < lend[i]);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b",
                   tag, cyc, obs, exp);
        end
    endtask

    // One clock: update the model at the edge, compare at the negedge
    task automatic step();
        bit pu [2];
        pu[0] = valid && reset && (pend[0].size() < D);
        pu[1] = valid_b && reset && (pend[1].size() < D);
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                pend[i].delete();
                have[i] = 1'b0;
                lend[i] = 0;
            end else begin
                if (pend[i].size() > 0 && cyc >= lend[i]) begin
                    ls[i]   = cyc;
                    lb[i]   = pend[i].pop_front();
                    lend[i] = cyc + 10 * cpb(i);
                    have[i] = 1'b1;
                end
                if (pu[i]) pend[i].push_back(i == 0 ? int'(din) : int'(din_b));
            end
        end
        @(negedge clk);
        chk("txd", txd, exp_txd(0));
        chk("ready", ready, logic'(pend[0].size() < D));
        chk("busy", busy, exp_busy(0));
        chk("txd_b", txd_b, exp_txd(1));
        chk("ready_b", ready_b, logic'(pend[1].size() < D));
        chk("busy_b", busy_b, exp_busy(1));
    endtask

    initial begin
        int  k;
        bit  seen;
        int  edges;
        logic prev;

        for (int i = 0; i < 2; i++) begin
            have[i] = 1'b0;
            lend[i] = 0;
            ls[i]   = 0;
            lb[i]   = 0;
        end
        reset   = 1'b0;
        valid   = 1'b0;
        din     = 8'h00;
        valid_b = 1'b0;
        din_b   = 8'h00;

        // reset held two cycles, then idle
        repeat (2) step();
        reset = 1'b1;
        repeat (20) step();

        // single byte 0xA5
        valid = 1'b1;
        din   = 8'hA5;
        step();
        valid = 1'b0;
        repeat (45) step();

        // burst 0x01..0x05 with valid held; stalls on full
        for (int b = 1; b <= 5; b++) begin
            valid = 1'b1;
            din   = 8'(b);
            seen  = 1'b0;
            k     = 0;
            while (!seen && k < 100) begin
                seen = ready;
                step();
                k++;
            end
            chk("burst_accept", seen, 1'b1);
        end
        valid = 1'b0;
        repeat (220) step();

        // sustained pressure: pushes coincide with pops while full
        for (int n = 0; n < 200; n++) begin
            valid = 1'b1;
            din   = 8'($urandom);
            step();
        end
        valid = 1'b0;
        repeat (220) step();

        // reset during data bit 3 with two bytes queued
        for (int n = 0; n < 3; n++) begin
            valid = 1'b1;
            din   = 8'($urandom);
            step();
        end
        valid = 1'b0;
        repeat (16) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (60) step();

        // random sparse traffic
        for (int n = 0; n < 300; n++) begin
            valid = ($urandom_range(0, 3) == 0);
            din   = 8'($urandom);
            step();
        end
        valid = 1'b0;
        repeat (220) step();

        // default divider: 0x55 toggles the line every bit
        valid_b = 1'b1;
        din_b   = 8'h55;
        step();
        valid_b = 1'b0;
        edges = 0;
        prev  = txd_b;
        for (int n = 0; n < 8700; n++) begin
            step();
            if (txd_b !== prev) edges++;
            prev = txd_b;
        end
        chk("big_edges", logic'(edges == 10), 1'b1);
        chk("big_idle", busy_b, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
